somador_arbiter: RTL

//  Shares one 16-bit signed add/sub unit (somador) between two requesters.

---
 rtl/somador_pkg.sv | 15 +
 rtl/somador.sv | 25 ++
 rtl/somador_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/somador_pkg.sv
// rtl/somador_pkg.sv - shared width, op codes and FSM encoding for the somador arbiter
package somador_pkg;

  localparam int WIDTH = 16;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/somador.sv
// rtl/somador.sv - combinational signed add/sub unit with two's complement overflow flag
module somador
  import somador_pkg::*;
#(
  parameter int W = somador_pkg::WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         overflow,
  output logic [W-1:0] result
);

  always_comb begin
    result   = (op == OP_ADD) ? (a + b) : (a - b);
    overflow = 1'b0;
    // Overflow iff operand signs force a sign the wrapped result does not have.
    if (op == OP_ADD) begin
      overflow = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
    end else begin
      overflow = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]);
    end
  end

endmodule

// File: rtl/somador_arbiter.sv
// rtl/somador_arbiter.sv - round-robin arbiter sharing one somador between two requesters
module somador_arbiter #(
  parameter int WIDTH = somador_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow
);
  import somador_pkg::*;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic             sel_valid;
  logic             sel_g;
  logic [WIDTH-1:0] sum_result;
  logic             sum_overflow;

  somador #(.W(WIDTH)) u_somador (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .overflow (sum_overflow),
    .result   (sum_result)
  );

  always_comb begin
    sel_valid = |req_valid;
    case (req_valid)
      2'b01:   sel_g = 1'b0;
      2'b10:   sel_g = 1'b1;
      default: sel_g = prio_q;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (reset_n && (state_q == ST_IDLE) && sel_valid) begin
      req_ready = {sel_g, ~sel_g};
    end
    rsp_valid    = (state_q == ST_RESP) ? {gnt_q, ~gnt_q} : 2'b00;
    rsp_result   = result_q;
    rsp_overflow = ovf_q;
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          // Explicit if/else keeps the losing requester's operands out of the mux.
          gnt_d = sel_g;
          if (sel_g) begin
            a_d  = req_a1;
            b_d  = req_b1;
            op_d = req_op[1];
          end else begin
            a_d  = req_a0;
            b_d  = req_b0;
            op_d = req_op[0];
          end
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = sum_result;
        ovf_d    = sum_overflow;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[gnt_q]) begin
          prio_d  = ~gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      gnt_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
